// File: rtl/ascon_pack.sv
// Shared types and round constants for the ASCON-128 sequencing controller.
package ascon_pack;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INIT      = 3'd1,
      WAIT_AD   = 3'd2,
      PERM_AD   = 3'd3,
      WAIT_TEXT = 3'd4,
      PERM_TEXT = 3'd5,
      FINAL     = 3'd6,
      DONE      = 3'd7
   } fsm_state_t;

   localparam logic [3:0] ROUND_A_START = 4'd0;
   localparam logic [3:0] ROUND_B_START = 4'd6;
   localparam logic [3:0] ROUND_LAST    = 4'd11;

endpackage

// File: rtl/compteur_double_init.sv
// 4-bit round counter with two load values: 0 for p^a phases, B_START for p^b phases.
module compteur_double_init
   import ascon_pack::*;
#(
   parameter logic [3:0] B_START = ROUND_B_START
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       en_i,
   input  logic       init_a_i,
   input  logic       init_b_i,
   output logic [3:0] count_o
);

   logic [3:0] count_q;
   logic [3:0] count_d;

   // Next count: loads take priority over increment, otherwise hold.
   always_comb begin
      count_d = count_q;
      if (init_a_i) begin
         count_d = ROUND_A_START;
      end else if (init_b_i) begin
         count_d = B_START;
      end else if (en_i) begin
         count_d = count_q + 4'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/ascon_fsm_ctrl.sv
// ASCON-128 AEAD sequencing controller: Moore FSM plus round counter driving
// the permutation enable, round index and XOR/mux selects of the datapath.
module ascon_fsm_ctrl
   import ascon_pack::*;
#(
   parameter int NB_ROUND_A = 12,
   parameter int NB_ROUND_B = 6
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic       ad_en_i,
   input  logic       data_valid_i,
   input  logic       data_last_i,
   output logic       ready_o,
   output logic [3:0] round_o,
   output logic       en_perm_o,
   output logic       sel_init_o,
   output logic       xor_data_begin_o,
   output logic       xor_key_begin_o,
   output logic       xor_key_end_o,
   output logic       xor_sep_o,
   output logic       en_cipher_o,
   output logic       en_tag_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam logic [3:0] R_B_START = 4'(NB_ROUND_A - NB_ROUND_B);
   localparam logic [3:0] R_LAST    = 4'(NB_ROUND_A - 1);

   fsm_state_t state_q, state_d;
   logic       ad_q, ad_d;
   logic       last_q, last_d;
   logic [3:0] cnt_s;
   logic       init_a_s, init_b_s, en_cnt_s;
   logic       at_last_s;

   assign at_last_s = (cnt_s == R_LAST);

   // Counter loads on phase entry; it stops at the last round so it never wraps.
   assign init_a_s = (state_d != state_q) && ((state_d == INIT) || (state_d == FINAL));
   assign init_b_s = (state_d != state_q) && ((state_d == PERM_AD) || (state_d == PERM_TEXT));
   assign en_cnt_s = en_perm_o && !at_last_s;

   compteur_double_init #(
      .B_START (R_B_START)
   ) u_cnt (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .en_i     (en_cnt_s),
      .init_a_i (init_a_s),
      .init_b_i (init_b_s),
      .count_o  (cnt_s)
   );

   // State and latched-flag registers.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         ad_q    <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ad_q    <= ad_d;
         last_q  <= last_d;
      end
   end

   // Next-state logic; blocks are consumed only in the WAIT states (ready_o high).
   always_comb begin
      state_d = state_q;
      ad_d    = ad_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               ad_d    = ad_en_i;
               state_d = INIT;
            end else begin
               state_d = IDLE;
            end
         end
         INIT: begin
            if (at_last_s) begin
               state_d = ad_q ? WAIT_AD : WAIT_TEXT;
            end else begin
               state_d = INIT;
            end
         end
         WAIT_AD: begin
            if (data_valid_i) begin
               last_d  = data_last_i;
               state_d = PERM_AD;
            end else begin
               state_d = WAIT_AD;
            end
         end
         PERM_AD: begin
            if (at_last_s) begin
               state_d = last_q ? WAIT_TEXT : WAIT_AD;
            end else begin
               state_d = PERM_AD;
            end
         end
         WAIT_TEXT: begin
            if (data_valid_i) begin
               state_d = data_last_i ? FINAL : PERM_TEXT;
            end else begin
               state_d = WAIT_TEXT;
            end
         end
         PERM_TEXT: begin
            if (at_last_s) begin
               state_d = WAIT_TEXT;
            end else begin
               state_d = PERM_TEXT;
            end
         end
         FINAL: begin
            if (at_last_s) begin
               state_d = DONE;
            end else begin
               state_d = FINAL;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore output decode from registered state and round counter.
   always_comb begin
      ready_o          = 1'b0;
      round_o          = cnt_s;
      en_perm_o        = 1'b0;
      sel_init_o       = 1'b0;
      xor_data_begin_o = 1'b0;
      xor_key_begin_o  = 1'b0;
      xor_key_end_o    = 1'b0;
      xor_sep_o        = 1'b0;
      en_cipher_o      = 1'b0;
      en_tag_o         = 1'b0;
      busy_o           = 1'b1;
      done_o           = 1'b0;
      case (state_q)
         IDLE: begin
            round_o = 4'd0;
            busy_o  = 1'b0;
         end
         INIT: begin
            en_perm_o     = 1'b1;
            sel_init_o    = (cnt_s == ROUND_A_START);
            xor_key_end_o = at_last_s;
            xor_sep_o     = at_last_s && !ad_q;
         end
         WAIT_AD, WAIT_TEXT: begin
            ready_o = 1'b1;
         end
         PERM_AD: begin
            en_perm_o        = 1'b1;
            xor_data_begin_o = (cnt_s == R_B_START);
            xor_sep_o        = at_last_s && last_q;
         end
         PERM_TEXT: begin
            en_perm_o        = 1'b1;
            xor_data_begin_o = (cnt_s == R_B_START);
            en_cipher_o      = (cnt_s == R_B_START);
         end
         FINAL: begin
            en_perm_o        = 1'b1;
            xor_data_begin_o = (cnt_s == ROUND_A_START);
            en_cipher_o      = (cnt_s == ROUND_A_START);
            xor_key_begin_o  = (cnt_s == ROUND_A_START);
            xor_key_end_o    = at_last_s;
            en_tag_o         = at_last_s;
         end
         DONE: begin
            done_o = 1'b1;
         end
         default: begin
            busy_o = 1'b0;
         end
      endcase
   end

endmodule
